audio_pwm_out: RTL and testbench
================================

Name: audio_pwm_out

Overview:
- Downstream stage of the ROM audio sample controller.
- Consumes its 8-bit unsigned samples, each qualified by a one-cycle `audio_valid` strobe, and drives a 1-bit PWM pin plus an amplifier shutdown line on the board.
- Each sample is double-buffered and applied only at a PWM period boundary, so the duty cycle never changes mid-period.
- Detects sample starvation and sample overwrite; on starvation, parks the output at midscale.

Parameters:
- PWM_PRESC, 1, clocks per PWM counter tick (range 1..65535). PWM frequency = clk / (256 * PWM_PRESC).
- TIMEOUT_PERIODS, 64, number of consecutive PWM periods without a new sample before underrun is declared (range 1..255).

Ports:
- clk  input  1  system clock (100 MHz).
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  output stage enable. Level-sensitive.
- audio_data  input  8  unsigned sample; midscale is 0x80.
- audio_valid  input  1  one-cycle strobe qualifying audio_data.
- clr_flags  input  1  clears the underrun and overrun flags.
- pwm_out  output  1  registered PWM output.
- sd_n  output  1  amplifier shutdown, active-low; equals the registered enable.
- period_start  output  1  one-cycle pulse in the first cycle of each PWM period.
- underrun  output  1  sticky starvation flag.
- overrun  output  1  sticky flag: a pending sample was overwritten before use.

Behaviour:
- Reset (reset=0, async) sets:
  - pwm_out=0, sd_n=0, period_start=0, underrun=0, overrun=0;
  - duty=0x80, pending_vld=0, pwm_cnt=0, presc_cnt=0, starve_cnt=0.
- Prescaler: presc_cnt counts 0..PWM_PRESC-1. `tick` is asserted when presc_cnt==PWM_PRESC-1. With PWM_PRESC=1, tick is high every cycle.
- PWM counter: pwm_cnt (8 bit) increments on tick and wraps 255->0. The boundary is tick && pwm_cnt==255.
- Output timing:
  - pwm_out <= enable_q && (pwm_cnt < duty), i.e. one cycle of latency from pwm_cnt.
  - duty=0 gives constant low; duty=255 gives high for 255 of 256 ticks.
- Pending buffer:
  - audio_valid loads pending<=audio_data and sets pending_vld=1.
  - If pending_vld is already 1 and no boundary occurs that cycle, the new sample overwrites pending and overrun is set.
- At each boundary:
  - If audio_valid is high in the same cycle: duty<=audio_data, pending_vld stays 0, overrun is not set.
  - Else if pending_vld=1: duty<=pending, pending_vld<=0.
  - Else if starve_cnt has reached TIMEOUT_PERIODS: duty<=0x80.
  - Else: duty is held.
- period_start is registered and high in the cycle after the boundary, while pwm_cnt==0.
- Starvation:
  - starve_cnt clears on any audio_valid.
  - Otherwise it increments at each boundary and saturates at TIMEOUT_PERIODS.
  - Reaching TIMEOUT_PERIODS sets underrun.
- Flags: clr_flags clears underrun and overrun. If a set condition occurs in the same cycle as clr_flags, set wins.
- Enable:
  - enable_q is enable registered once; sd_n = enable_q.
  - While enable_q=0: pwm_out=0, pwm_cnt and presc_cnt are held at 0, pending_vld is cleared, duty=0x80, starve_cnt=0, period_start=0. audio_valid is ignored.
  - On the first cycle with enable_q=1, counting starts from pwm_cnt=0.
- Mid-operation reset: everything returns to reset values immediately, regardless of clk.

Optional Feature:
- Macro: AUDIO_PWM_VOLUME_EN.
- When defined:
  - Adds input port volume [2:0].
  - The sample loaded into duty is attenuated around midscale: duty = 0x80 + ((s - 0x80) >>> volume), using a 9-bit signed intermediate with an arithmetic shift.
  - volume=0 means no change; volume=7 gives ≈ midscale.
- When undefined: no volume port, and samples pass through unchanged.

Decomposition:
- Package audio_pkg holds:
  - localparam AUDIO_W=8 and AUDIO_MID=8'h80;
  - the period-boundary helper constant PWM_MAX=8'hFF.
- One natural sub-module, audio_pwm_core: prescaler, pwm_cnt, compare and the pwm_out register, with inputs duty and run.
- The top level keeps the pending buffer, starvation logic, flags and volume scaling.

Test Plan:
- Reset/idle: reset=0 then release with enable=0 -> pwm_out=0, sd_n=0, flags 0. Set enable=1 -> sd_n=1 one cycle later; first period runs at duty 0x80, giving 128 high ticks per 256.
- Duty accuracy: PWM_PRESC=1; send 0x40 then 0xFF then 0x00 via audio_valid, one per period -> high counts of 64, 255 and 0 in the following periods; duty changes only after period_start.
- Boundary collision: assert audio_valid=1 with 0x20 exactly at the boundary cycle -> next period duty=0x20, pending_vld=0, overrun=0.
- Overrun: two audio_valid strobes (0x10, then 0x90) within one period -> overrun=1, next duty=0x90. Pulse clr_flags -> overrun=0.
- Underrun: TIMEOUT_PERIODS=4; last sample 0xC0, then none -> underrun sets at the 4th boundary and duty becomes 0x80 from the following period. A new sample clears starve_cnt; underrun stays set until clr_flags.
- Reset mid-period: assert reset during a high phase of pwm_out -> pwm_out drops asynchronously, duty=0x80, and all flags clear.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg
// Shared constants for the audio PWM output stage: sample width, the
// midscale value used when the stage is idle or starved, and the last
// PWM counter value that marks a period boundary.
// With AUDIO_PWM_VOLUME_EN defined it also provides the attenuation helper
// used by the top level.
package audio_pkg;

  localparam int         AUDIO_W   = 8;
  localparam logic [7:0] AUDIO_MID = 8'h80;
  localparam logic [7:0] PWM_MAX   = 8'hFF;

`ifdef AUDIO_PWM_VOLUME_EN
  // Attenuate a sample around midscale.
  // The sample is re-centred on zero in a 9-bit signed value. It is then
  // shifted arithmetically and moved back up by midscale. Because the
  // shifted value stays inside -128..127, the result always fits 8 bits.
  function automatic logic [AUDIO_W-1:0] atten(input logic [AUDIO_W-1:0] s,
                                                input logic [2:0]         vol);
    logic signed [8:0] diff;
    logic signed [8:0] res;
    diff = $signed({1'b0, s}) - $signed({1'b0, AUDIO_MID});
    res  = (diff >>> vol) + $signed({1'b0, AUDIO_MID});
    return res[AUDIO_W-1:0];
  endfunction
`endif

endpackage

// File: rtl/audio_pwm_core.sv
// audio_pwm_core
// Free-running PWM generator: prescaler, 8-bit period counter, duty compare
// and the registered PWM pin.
//   clk       system clock
//   reset     asynchronous active-low reset
//   run       counting enable; while low the counters are held at zero and
//             the pin is held low
//   duty      compare value; the pin is high while the counter is below it
//   boundary  combinational; high in the last tick of a PWM period
//   pwm_out   registered PWM pin
module audio_pwm_core
  import audio_pkg::*;
#(
  parameter int PWM_PRESC = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [AUDIO_W-1:0] duty,
  output logic               boundary,
  output logic               pwm_out
);

  localparam logic [15:0] PRESC_LAST = 16'(PWM_PRESC - 1);

  logic [15:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]  pwm_cnt_q,   pwm_cnt_d;
  logic        pwm_out_q,   pwm_out_d;
  logic        tick;

  // Prescaler and period counter. The compare uses the current counter, so
  // the pin lags the counter by exactly one clock.
  always_comb begin
    presc_cnt_d = presc_cnt_q;
    pwm_cnt_d   = pwm_cnt_q;
    tick        = run && (presc_cnt_q == PRESC_LAST);
    boundary    = tick && (pwm_cnt_q == PWM_MAX);
    if (!run) begin
      presc_cnt_d = '0;
      pwm_cnt_d   = '0;
    end else if (tick) begin
      presc_cnt_d = '0;
      pwm_cnt_d   = pwm_cnt_q + 8'd1;
    end else begin
      presc_cnt_d = presc_cnt_q + 16'd1;
    end
    pwm_out_d = run && (pwm_cnt_q < duty);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      pwm_out_q   <= 1'b0;
    end else begin
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      pwm_out_q   <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;

endmodule

// File: rtl/audio_pwm_out.sv
// audio_pwm_out
// Output stage behind the ROM audio sample controller.
// Incoming samples are double-buffered, and a sample is applied only at a
// PWM period boundary.
// Starvation and overwrite are tracked with sticky flags. If samples stop
// arriving, the output is parked at midscale.
//   clk           system clock
//   reset         asynchronous active-low reset
//   enable        output stage enable, level-sensitive
//   audio_data    unsigned 8-bit sample, midscale 0x80
//   audio_valid   one-cycle strobe qualifying audio_data
//   clr_flags     clears underrun and overrun (a same-cycle set wins)
//   volume        (AUDIO_PWM_VOLUME_EN only) attenuation shift 0..7
//   pwm_out       registered PWM pin
//   sd_n          amplifier shutdown, active-low (registered enable)
//   period_start  one-cycle pulse in the first cycle of each PWM period
//   underrun      sticky starvation flag
//   overrun       sticky flag for a pending sample lost before use
// Optional feature macro: AUDIO_PWM_VOLUME_EN adds the volume port.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int PWM_PRESC       = 1,
  parameter int TIMEOUT_PERIODS = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [AUDIO_W-1:0] audio_data,
  input  logic               audio_valid,
  input  logic               clr_flags,
`ifdef AUDIO_PWM_VOLUME_EN
  input  logic [2:0]         volume,
`endif
  output logic               pwm_out,
  output logic               sd_n,
  output logic               period_start,
  output logic               underrun,
  output logic               overrun
);

  localparam logic [7:0] STARVE_MAX = 8'(TIMEOUT_PERIODS);
  localparam logic [7:0] STARVE_ARM = 8'(TIMEOUT_PERIODS - 1);

  logic               enable_q;
  logic [AUDIO_W-1:0] duty_q,         duty_d;
  logic [AUDIO_W-1:0] pending_q,      pending_d;
  logic               pending_vld_q,  pending_vld_d;
  logic [7:0]         starve_cnt_q,   starve_cnt_d;
  logic               underrun_q,     underrun_d;
  logic               overrun_q,      overrun_d;
  logic               period_start_q, period_start_d;
  logic               boundary;
  logic               valid_in;
  logic [AUDIO_W-1:0] sample_s;

  // Samples are scaled on entry, so the pending buffer and duty hold
  // values that are ready to use.
`ifdef AUDIO_PWM_VOLUME_EN
  assign sample_s = atten(audio_data, volume);
`else
  assign sample_s = audio_data;
`endif

  audio_pwm_core #(
    .PWM_PRESC(PWM_PRESC)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .run      (enable_q),
    .duty     (duty_q),
    .boundary (boundary),
    .pwm_out  (pwm_out)
  );

  // Enable is registered once. That registered copy drives both the
  // amplifier shutdown pin and the core run input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q <= 1'b0;
    end else begin
      enable_q <= enable;
    end
  end

  // Double buffer, starvation counter and flags.
  // A strobe that lands on the boundary cycle goes straight into duty. This
  // means the pending slot is never involved, so no overwrite is flagged.
  // The starvation check uses the registered count. As a result, the period
  // in which underrun rises still plays the old duty, and midscale follows
  // one period later.
  always_comb begin
    duty_d         = duty_q;
    pending_d      = pending_q;
    pending_vld_d  = pending_vld_q;
    starve_cnt_d   = starve_cnt_q;
    period_start_d = boundary;
    valid_in       = enable_q && audio_valid;

    if (!enable_q) begin
      duty_d        = AUDIO_MID;
      pending_vld_d = 1'b0;
      starve_cnt_d  = '0;
    end else begin
      if (valid_in) begin
        starve_cnt_d = '0;
      end else if (boundary && (starve_cnt_q != STARVE_MAX)) begin
        starve_cnt_d = starve_cnt_q + 8'd1;
      end

      if (boundary) begin
        if (valid_in) begin
          duty_d        = sample_s;
          pending_vld_d = 1'b0;
        end else if (pending_vld_q) begin
          duty_d        = pending_q;
          pending_vld_d = 1'b0;
        end else if (starve_cnt_q == STARVE_MAX) begin
          duty_d = AUDIO_MID;
        end
      end else if (valid_in) begin
        pending_d     = sample_s;
        pending_vld_d = 1'b1;
      end
    end

    overrun_d = overrun_q;
    if (valid_in && !boundary && pending_vld_q) begin
      overrun_d = 1'b1;
    end else if (clr_flags) begin
      overrun_d = 1'b0;
    end

    underrun_d = underrun_q;
    if (boundary && !valid_in && (starve_cnt_q == STARVE_ARM)) begin
      underrun_d = 1'b1;
    end else if (clr_flags) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q         <= AUDIO_MID;
      pending_q      <= '0;
      pending_vld_q  <= 1'b0;
      starve_cnt_q   <= '0;
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      duty_q         <= duty_d;
      pending_q      <= pending_d;
      pending_vld_q  <= pending_vld_d;
      starve_cnt_q   <= starve_cnt_d;
      underrun_q     <= underrun_d;
      overrun_q      <= overrun_d;
      period_start_q <= period_start_d;
    end
  end

  assign sd_n         = enable_q;
  assign period_start = period_start_q;
  assign underrun     = underrun_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// tb_audio_pwm_out
// Directed bench for audio_pwm_out with PWM_PRESC=1 and TIMEOUT_PERIODS=4.
// The stimulus pushes the expected high-tick count of each upcoming PWM
// period into a queue. The monitor measures every complete period delimited
// by enable start / period_start and compares it against the queue head.
module tb_audio_pwm_out;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [7:0] audioData;
  logic       audioValid;
  logic       clrFlags;
  logic       pwmOut;
  logic       sdN;
  logic       periodStart;
  logic       underrunFlag;
  logic       overrunFlag;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int idx;
    int high;
  } expEntry_t;

  expEntry_t expQ[$];

  int periodIdx = 0;
  int curIdx    = 0;
  int highCnt   = 0;
  bit measuring = 0;
  bit sdPrev    = 0;

  audio_pwm_out #(
    .PWM_PRESC       (1),
    .TIMEOUT_PERIODS (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .audio_data   (audioData),
    .audio_valid  (audioValid),
    .clr_flags    (clrFlags),
`ifdef AUDIO_PWM_VOLUME_EN
    .volume       (3'd0),
`endif
    .pwm_out      (pwmOut),
    .sd_n         (sdN),
    .period_start (periodStart),
    .underrun     (underrunFlag),
    .overrun      (overrunFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports failures
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // One-cycle audio_valid strobe, optionally with clr_flags in the same cycle
  task automatic applyStimulus(input logic [7:0] data, input logic clr);
    @(posedge clk);
    #1;
    audioData  = data;
    audioValid = 1'b1;
    clrFlags   = clr;
    @(posedge clk);
    #1;
    audioValid = 1'b0;
    clrFlags   = 1'b0;
  endtask

  task automatic pulseClr();
    @(posedge clk);
    #1;
    clrFlags = 1'b1;
    @(posedge clk);
    #1;
    clrFlags = 1'b0;
  endtask

  task automatic waitPeriodStart();
    bit found;
    found = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (periodStart === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (!found) checkOutput("period_start_timeout", 0, 1);
  endtask

  task automatic waitSdHigh();
    bit found;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (sdN === 1'b1) begin
        found = 1;
        break;
      end
    end
    if (!found) checkOutput("sd_n_timeout", 0, 1);
  endtask

  task automatic expectAt(input int idx, input int high);
    expEntry_t e;
    e.idx  = idx;
    e.high = high;
    expQ.push_back(e);
  endtask

  task automatic finalizePeriod(input int idx, input int high);
    expEntry_t e;
    while (expQ.size() > 0 && expQ[0].idx < idx) begin
      e = expQ.pop_front();
      checkOutput($sformatf("period%0d_never_completed", e.idx), idx, e.idx);
    end
    if (expQ.size() > 0 && expQ[0].idx == idx) begin
      e = expQ.pop_front();
      checkOutput($sformatf("period%0d_high_ticks", idx), high, e.high);
    end
  endtask

  // Monitor: pwm_out in the period_start cycle still belongs to the period
  // that is ending, so it is counted before that period is closed.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      measuring = 0;
      sdPrev    = 0;
    end else begin
      if (measuring && sdN !== 1'b1) measuring = 0;
      if (measuring && pwmOut === 1'b1) highCnt++;
      if (periodStart === 1'b1) begin
        if (measuring) finalizePeriod(curIdx, highCnt);
        periodIdx++;
        curIdx    = periodIdx;
        highCnt   = 0;
        measuring = 1;
      end else if (sdN === 1'b1 && !sdPrev) begin
        periodIdx++;
        curIdx    = periodIdx;
        highCnt   = 0;
        measuring = 1;
      end
      sdPrev = (sdN === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  // Directed sequence
  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    audioData  = 8'h00;
    audioValid = 1'b0;
    clrFlags   = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_pwm_out", pwmOut, 0);
    checkOutput("reset_sd_n", sdN, 0);
    checkOutput("reset_period_start", periodStart, 0);
    checkOutput("reset_underrun", underrunFlag, 0);
    checkOutput("reset_overrun", overrunFlag, 0);

    // Released but disabled: strobes are ignored
    @(posedge clk);
    #1;
    reset = 1'b1;
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("idle_pwm_out", pwmOut, 0);
    checkOutput("idle_sd_n", sdN, 0);
    checkOutput("idle_period_start", periodStart, 0);
    checkOutput("idle_overrun", overrunFlag, 0);

    // Enable: sd_n follows one cycle later, first period at midscale
    @(posedge clk);
    #1;
    enable = 1'b1;
    @(negedge clk);
    checkOutput("sd_n_before_register", sdN, 0);
    @(negedge clk);
    #1;
    checkOutput("sd_n_after_register", sdN, 1);
    expectAt(periodIdx, 128);

    // Duty accuracy: one sample per period
    applyStimulus(8'h40, 1'b0);
    expectAt(periodIdx + 1, 64);
    waitPeriodStart();
    applyStimulus(8'hFF, 1'b0);
    expectAt(periodIdx + 1, 255);
    waitPeriodStart();
    applyStimulus(8'h00, 1'b0);
    expectAt(periodIdx + 1, 0);
    waitPeriodStart();

    // Boundary collision: strobe exactly in the cnt==255 cycle
    expectAt(periodIdx + 1, 32);
    repeat (255) @(posedge clk);
    #1;
    audioData  = 8'h20;
    audioValid = 1'b1;
    @(posedge clk);
    #1;
    audioValid = 1'b0;
    waitPeriodStart();
    checkOutput("collision_overrun", overrunFlag, 0);
    expectAt(periodIdx + 1, 96);
    applyStimulus(8'h60, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("collision_pending_clear", overrunFlag, 0);

    // Overrun: two strobes in one period, the second one wins
    waitPeriodStart();
    expectAt(periodIdx + 1, 144);
    applyStimulus(8'h10, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("single_pending_no_overrun", overrunFlag, 0);
    applyStimulus(8'h90, 1'b0);
    @(negedge clk);
    checkOutput("overrun_set", overrunFlag, 1);
    checkOutput("underrun_still_clear", underrunFlag, 0);
    pulseClr();
    @(negedge clk);
    checkOutput("overrun_cleared", overrunFlag, 0);

    // Underrun: last sample 0xC0, then starvation
    waitPeriodStart();
    applyStimulus(8'hC0, 1'b0);
    for (int k = 1; k <= 4; k++) expectAt(periodIdx + k, 192);
    expectAt(periodIdx + 5, 128);
    waitPeriodStart();
    waitPeriodStart();
    waitPeriodStart();
    checkOutput("underrun_after_3_boundaries", underrunFlag, 0);
    waitPeriodStart();
    checkOutput("underrun_after_4_boundaries", underrunFlag, 1);
    waitPeriodStart();
    applyStimulus(8'h50, 1'b0);
    expectAt(periodIdx + 1, 80);
    repeat (3) @(negedge clk);
    checkOutput("underrun_sticky", underrunFlag, 1);
    pulseClr();
    @(negedge clk);
    checkOutput("underrun_cleared", underrunFlag, 0);

    // Set wins over a same-cycle clear
    waitPeriodStart();
    expectAt(periodIdx + 1, 168);
    applyStimulus(8'hA0, 1'b0);
    repeat (3) @(negedge clk);
    applyStimulus(8'hA8, 1'b1);
    @(negedge clk);
    checkOutput("overrun_set_beats_clear", overrunFlag, 1);
    pulseClr();
    @(negedge clk);
    checkOutput("overrun_cleared_again", overrunFlag, 0);

    // Reset in the middle of a high phase
    waitPeriodStart();
    applyStimulus(8'h30, 1'b0);
    applyStimulus(8'h31, 1'b0);
    @(negedge clk);
    checkOutput("overrun_before_reset", overrunFlag, 1);
    waitPeriodStart();
    repeat (10) @(negedge clk);
    checkOutput("pwm_high_before_reset", pwmOut, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("async_reset_pwm_out", pwmOut, 0);
    checkOutput("async_reset_overrun", overrunFlag, 0);
    checkOutput("async_reset_underrun", underrunFlag, 0);
    checkOutput("async_reset_sd_n", sdN, 0);
    checkOutput("async_reset_period_start", periodStart, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    waitSdHigh();
    expectAt(periodIdx, 128);
    waitPeriodStart();
    repeat (2) @(negedge clk);

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
